// File: rtl/wrap_count_checker.sv
// rtl/wrap_count_checker.sv - lock-and-predict checker for a LOW..HIGH wrapping counter stream
module wrap_count_checker #(
  parameter int                WIDTH      = 32,
  parameter logic [WIDTH-1:0]  LOW        = WIDTH'(1),
  parameter logic [WIDTH-1:0]  HIGH       = WIDTH'(10),
  parameter int                LOCK_COUNT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  input  logic             clear_errors,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic             range_err,
  output logic             wrap_pulse,
  output logic [15:0]      wrap_count,
  output logic [7:0]       error_count,
  output logic             sticky_error
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t           state, state_n;
  logic [RUN_W-1:0] match_run, match_run_n, run_inc;
  logic [WIDTH-1:0] expected_n, next_value;
  logic             mismatch_n, range_err_n, wrap_pulse_n, sticky_error_n;
  logic [15:0]      wrap_count_n;
  logic [7:0]       error_count_n;
  logic             in_range;

  assign in_range   = (in_value >= LOW) && (in_value <= HIGH);
  assign next_value = (in_value == HIGH) ? LOW : in_value + WIDTH'(1);
  assign run_inc    = match_run + RUN_W'(1);
  assign locked     = (state == LOCKED);

  always_comb begin
    state_n        = state;
    match_run_n    = match_run;
    expected_n     = expected;
    mismatch_n     = 1'b0;
    range_err_n    = 1'b0;
    wrap_pulse_n   = 1'b0;
    wrap_count_n   = wrap_count;
    error_count_n  = error_count;
    sticky_error_n = sticky_error;

    if (clear_errors) begin
      error_count_n  = 8'd0;
      sticky_error_n = 1'b0;
    end

    if (in_valid) begin
      unique case (state)
        SEARCH: begin
          if (in_range) begin
            expected_n  = next_value;
            match_run_n = '0;
            state_n     = ACQUIRE;
          end else begin
            range_err_n = 1'b1;
          end
        end
        ACQUIRE: begin
          if (!in_range) begin
            range_err_n = 1'b1;
            state_n     = SEARCH;
          end else if (in_value == expected) begin
            expected_n  = next_value;
            match_run_n = run_inc;
            if (run_inc == RUN_W'(LOCK_COUNT)) state_n = LOCKED;
          end else begin
            // A fresh in-range value re-seeds the prediction rather than flagging.
            expected_n  = next_value;
            match_run_n = '0;
          end
        end
        LOCKED: begin
          if (in_value == expected) begin
            expected_n = next_value;
            if (in_value == LOW) begin
              wrap_pulse_n = 1'b1;
              wrap_count_n = wrap_count + 16'd1;
            end
          end else begin
            mismatch_n     = 1'b1;
            range_err_n    = !in_range;
            sticky_error_n = 1'b1;
            // A mismatch on the same edge as clear_errors counts as the first new error.
            if (clear_errors)              error_count_n = 8'd1;
            else if (error_count != 8'hFF) error_count_n = error_count + 8'd1;
            state_n = SEARCH;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= SEARCH;
      match_run    <= '0;
      expected     <= LOW;
      mismatch     <= 1'b0;
      range_err    <= 1'b0;
      wrap_pulse   <= 1'b0;
      wrap_count   <= 16'd0;
      error_count  <= 8'd0;
      sticky_error <= 1'b0;
    end else begin
      state        <= state_n;
      match_run    <= match_run_n;
      expected     <= expected_n;
      mismatch     <= mismatch_n;
      range_err    <= range_err_n;
      wrap_pulse   <= wrap_pulse_n;
      wrap_count   <= wrap_count_n;
      error_count  <= error_count_n;
      sticky_error <= sticky_error_n;
    end
  end

endmodule

// File: tb/tb_wrap_count_checker.sv
// tb/tb_wrap_count_checker.sv - scoreboard bench for wrap_count_checker with a chain-length reference model
module tb_wrap_count_checker;

  localparam int unsigned LOW  = 1;
  localparam int unsigned HIGH = 10;
  localparam int          LC   = 2;

  logic        clock = 1'b0;
  logic        reset, in_valid, clear_errors;
  logic [31:0] in_value;
  logic        locked, mismatch, range_err, wrap_pulse, sticky_error;
  logic [31:0] expected;
  logic [15:0] wrap_count;
  logic [7:0]  error_count;

  wrap_count_checker dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_value     (in_value),
    .clear_errors (clear_errors),
    .locked       (locked),
    .expected     (expected),
    .mismatch     (mismatch),
    .range_err    (range_err),
    .wrap_pulse   (wrap_pulse),
    .wrap_count   (wrap_count),
    .error_count  (error_count),
    .sticky_error (sticky_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          lk;
    bit          mm;
    bit          re;
    bit          wp;
    int unsigned ex;
    bit          ex_chk;
    int unsigned wc;
    int unsigned ec;
    bit          st;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;

  // Model: length of the current chain of consecutive successor values.
  // Zero means searching; more than LC samples in the chain means locked.
  int          chain = 0;
  int unsigned m_exp = LOW;
  bit          m_exp_known = 1'b0;
  int unsigned m_wc = 0;
  int unsigned m_ec = 0;
  bit          m_st = 1'b0;
  int unsigned src = LOW;

  function automatic int unsigned succ(int unsigned v);
    return (v == HIGH) ? LOW : v + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit val, input int unsigned v, input bit clr);
    resp_t r;
    bit    inr, hit;
    @(negedge clock);
    reset        = rst;
    in_valid     = val;
    in_value     = v;
    clear_errors = clr;
    r.mm = 0;
    r.re = 0;
    r.wp = 0;
    if (rst) begin
      chain       = 0;
      m_exp       = LOW;
      m_exp_known = 1;
      m_wc        = 0;
      m_ec        = 0;
      m_st        = 0;
    end else begin
      if (clr) begin
        m_ec = 0;
        m_st = 0;
      end
      if (val) begin
        inr = (v >= LOW) && (v <= HIGH);
        hit = (chain > 0) && (v == m_exp);
        if (chain > LC) begin
          if (hit) begin
            m_exp = succ(v);
            if (v == LOW) begin
              r.wp = 1;
              m_wc = (m_wc + 1) % 65536;
            end
          end else begin
            r.mm  = 1;
            r.re  = !inr;
            m_st  = 1;
            m_ec  = clr ? 1 : ((m_ec < 255) ? m_ec + 1 : 255);
            chain = 0;
          end
        end else if (!inr) begin
          r.re  = 1;
          chain = 0;
        end else begin
          chain = hit ? chain + 1 : 1;
          m_exp = succ(v);
        end
        m_exp_known = (chain > 0);
      end
    end
    r.lk     = (chain > LC);
    r.ex     = m_exp;
    r.ex_chk = m_exp_known;
    r.wc     = m_wc;
    r.ec     = m_ec;
    r.st     = m_st;
    sb.push_back(r);
  endtask

  task automatic feed(input int unsigned v);
    step(0, 1, v, 0);
  endtask

  initial begin
    resp_t r;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("locked", 32'(locked), 32'(r.lk));
        chk("mismatch", 32'(mismatch), 32'(r.mm));
        chk("range_err", 32'(range_err), 32'(r.re));
        chk("wrap_pulse", 32'(wrap_pulse), 32'(r.wp));
        chk("wrap_count", 32'(wrap_count), r.wc);
        chk("error_count", 32'(error_count), r.ec);
        chk("sticky_error", 32'(sticky_error), 32'(r.st));
        if (r.ex_chk) chk("expected", expected, r.ex);
      end
    end
  end

  initial begin
    int unsigned p, v;
    reset        = 1;
    in_valid     = 0;
    in_value     = 0;
    clear_errors = 0;
    step(1, 0, 0, 0);
    step(1, 1, 5, 1);

    // Acquire and lock on 3,4,5, then run through a wrap.
    feed(3); feed(4); feed(5);
    feed(6); feed(7); feed(8); feed(9); feed(10); feed(1); feed(2);
    // Mismatch while locked, then reacquire.
    feed(3); feed(4); feed(7);
    feed(8); feed(9); feed(10);
    // Out-of-range while locked, then in SEARCH, then while locked.
    feed(0); feed(0); feed(11);
    feed(1); feed(2); feed(3); feed(12);

    // Saturate error_count, then clear with and without a concurrent mismatch.
    for (int i = 0; i < 256; i++) begin
      feed(1); feed(2); feed(3); feed(7);
    end
    feed(1); feed(2); feed(3);
    step(0, 1, 7, 1);
    step(0, 0, 0, 1);

    // Reset mid-lock with a valid sample, then a gap while locked.
    feed(1); feed(2); feed(3);
    step(1, 1, 4, 0);
    feed(1); feed(2); feed(3);
    step(0, 0, 9, 0); step(0, 0, 4, 0); step(0, 0, 0, 0);
    feed(4); feed(5);

    // Randomized traffic around a wrapping source.
    src = 5;
    for (int i = 0; i < 1500; i++) begin
      p = $urandom_range(0, 99);
      if (p < 2) begin
        step(1, 1'($urandom_range(0, 1)), succ(src), 0);
      end else if (p < 12) begin
        step(0, 0, $urandom, 1'($urandom_range(0, 9) == 0));
      end else if (p < 17) begin
        v   = $urandom_range(LOW, HIGH);
        src = v;
        step(0, 1, v, 1'($urandom_range(0, 9) == 0));
      end else if (p < 22) begin
        case ($urandom_range(0, 2))
          0:       v = 0;
          1:       v = HIGH + 1;
          default: v = $urandom_range(HIGH + 1, 32'hFFFF_FFFF);
        endcase
        step(0, 1, v, 0);
      end else begin
        src = succ(src);
        step(0, 1, src, 1'($urandom_range(0, 19) == 0));
      end
    end

    step(0, 0, 0, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
